pdmem: RTL and testbench

PDMEM -- requirements
Module: pdmem

---
 rtl/pdmem_pkg.sv | 13 +
 rtl/pdmem_clr.sv | 58 +++++
 rtl/pdmem.sv | 90 +++++++++
 tb/tb_pdmem.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdmem_pkg.sv
// Shared types and default parameters for the pdmem self-clearing memory.
package pdmem_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 64;
  localparam int DEF_SEED   = 1;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } pdmem_state_e;

endpackage

// File: rtl/pdmem_clr.sv
// Clear sequencer: walks every word once after reset and then hands the array over.
//
// state | meaning
// CLEAR | one word per cycle is overwritten; pointer advances from 0 to DEPTH-1
// READY | clear finished; user reads and writes own the array
module pdmem_clr
  import pdmem_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              done,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_ptr,
  output logic              clr_seed
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  pdmem_state_e      state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      CLEAR: begin
        if (ptr_q == LAST) begin
          state_d = READY;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      READY:   state_d = READY;
      default: state_d = CLEAR;
    endcase
  end

  // rst is synchronous, so a cycle with rst high must not write even though state is CLEAR.
  assign done     = (state_q == READY);
  assign clr_we   = (state_q == CLEAR) && !rst;
  assign clr_ptr  = ptr_q;
  assign clr_seed = (ptr_q <= ADDR_W'(1));

endmodule

// File: rtl/pdmem.sv
// Single-port-pair memory that self-clears (words 0/1 = SEED) after reset.
// Build option: define PDMEM_FWD_EN so a same-address same-cycle read returns the new write data.
module pdmem
  import pdmem_pkg::*;
#(
  parameter int  DATA_W = DEF_DATA_W,
  parameter int  DEPTH  = DEF_DEPTH,
  parameter int  SEED   = DEF_SEED,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err,
  output logic              wr_err
);

  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
  localparam logic [DATA_W-1:0] SEED_W  = DATA_W'(SEED);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              done;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_ptr;
  logic              clr_seed;
  logic              wr_in, rd_in;
  logic              wr_ok, wr_bad, rd_fire;
  logic [DATA_W-1:0] rd_word;

  pdmem_clr #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clr (
    .clk      (clk),
    .rst      (rst),
    .done     (done),
    .clr_we   (clr_we),
    .clr_ptr  (clr_ptr),
    .clr_seed (clr_seed)
  );

  // Zero-extend so the range check also works when DEPTH is not a power of two.
  assign wr_in   = ({1'b0, wr_addr} < DEPTH_X);
  assign rd_in   = ({1'b0, rd_addr} < DEPTH_X);
  assign wr_ok   = done && !rst && wr_en && wr_in;
  assign wr_bad  = done && !rst && wr_en && !wr_in;
  assign rd_fire = done && !rst && rd_en;
  assign busy    = !done;

`ifdef PDMEM_FWD_EN
  assign rd_word = (wr_ok && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
`else
  assign rd_word = mem[rd_addr];
`endif

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_ptr] <= clr_seed ? SEED_W : '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_err   <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      rd_valid <= rd_fire;
      rd_err   <= rd_fire && !rd_in;
      if (rd_fire) begin
        rd_data <= rd_in ? rd_word : '0;
      end
      if (wr_bad) begin
        wr_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pdmem.sv
// Self-checking bench for pdmem: a default (DEPTH=64) instance and a DEPTH=48 instance.
module tb_pdmem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=64 instance
  logic       rst, busy, wr_en, rd_en, rd_valid, rd_err, wr_err;
  logic [5:0] wr_addr, rd_addr;
  logic [7:0] wr_data, rd_data;

  // DEPTH=48 instance
  logic       rst_b, busy_b, wr_en_b, rd_en_b, rd_valid_b, rd_err_b, wr_err_b;
  logic [5:0] wr_addr_b, rd_addr_b;
  logic [7:0] wr_data_b, rd_data_b;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] model   [64];
  logic [7:0] model48 [48];

`ifdef PDMEM_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  pdmem u_dut (
    .clk      (clk),
    .rst      (rst),
    .busy     (busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_err   (rd_err),
    .wr_err   (wr_err)
  );

  pdmem #(.DEPTH(48)) u_dut48 (
    .clk      (clk),
    .rst      (rst_b),
    .busy     (busy_b),
    .wr_en    (wr_en_b),
    .wr_addr  (wr_addr_b),
    .wr_data  (wr_data_b),
    .rd_en    (rd_en_b),
    .rd_addr  (rd_addr_b),
    .rd_valid (rd_valid_b),
    .rd_data  (rd_data_b),
    .rd_err   (rd_err_b),
    .wr_err   (wr_err_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 64; i++) model[i] = (i < 2) ? 8'h01 : 8'h00;
    for (int i = 0; i < 48; i++) model48[i] = (i < 2) ? 8'h01 : 8'h00;
  endfunction

  task automatic test_reset();
    int n;
    rst = 1'b1;
    idle();
    tick(); tick(); tick();
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy got %b want 1", busy); end
    n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
    n_tests++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data got %h want 00", rd_data); end
    n_tests++; if (rd_err !== 1'b0) begin n_fail++; $display("FAIL reset_rd_err got %b want 0", rd_err); end
    n_tests++; if (wr_err !== 1'b0) begin n_fail++; $display("FAIL reset_wr_err got %b want 0", wr_err); end
    rst = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 200) begin n++; tick(); end
    n_tests++; if (n != 64) begin n_fail++; $display("FAIL clear_len got %0d want 64", n); end
    model_clear();
    rd_en = 1'b1;
    for (int a = 0; a < 3; a++) begin
      rd_addr = 6'(a);
      tick();
      n_tests++;
      if (rd_valid !== 1'b1 || rd_data !== model[a] || rd_err !== 1'b0) begin
        n_fail++;
        $display("FAIL seed_read addr %0d got v=%b d=%h e=%b want v=1 d=%h e=0", a, rd_valid, rd_data, rd_err, model[a]);
      end
    end
    rd_en = 1'b0;
    tick();
    n_tests++;
    if (rd_valid !== 1'b0 || rd_data !== 8'h00 || rd_err !== 1'b0) begin
      n_fail++; $display("FAIL rd_hold got v=%b d=%h e=%b want v=0 d=00 e=0", rd_valid, rd_data, rd_err);
    end
  endtask

  task automatic test_write_read();
    wr_en = 1'b1; wr_addr = 6'd10; wr_data = 8'hA5;
    tick();
    model[10] = 8'hA5;
    wr_en = 1'b0;
    n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL wr_no_valid got %b want 0", rd_valid); end
    rd_en = 1'b1; rd_addr = 6'd10;
    tick();
    rd_en = 1'b0;
    n_tests++;
    if (rd_valid !== 1'b1 || rd_data !== 8'hA5 || rd_err !== 1'b0) begin
      n_fail++; $display("FAIL read_a5 got v=%b d=%h e=%b want v=1 d=a5 e=0", rd_valid, rd_data, rd_err);
    end
    tick();
    n_tests++;
    if (rd_valid !== 1'b0 || rd_data !== 8'hA5) begin
      n_fail++; $display("FAIL read_a5_hold got v=%b d=%h want v=0 d=a5", rd_valid, rd_data);
    end
  endtask

  task automatic test_read_during_write();
    logic [7:0] want;
    wr_en = 1'b1; wr_addr = 6'd5; wr_data = 8'h11;
    tick();
    wr_data = 8'h22; rd_en = 1'b1; rd_addr = 6'd5;
    tick();
    wr_en = 1'b0;
    want = FWD ? 8'h22 : 8'h11;
    n_tests++;
    if (rd_valid !== 1'b1 || rd_data !== want) begin
      n_fail++; $display("FAIL rdw_same got v=%b d=%h want v=1 d=%h", rd_valid, rd_data, want);
    end
    tick();
    rd_en = 1'b0;
    model[5] = 8'h22;
    n_tests++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h22) begin
      n_fail++; $display("FAIL rdw_after got v=%b d=%h want v=1 d=22", rd_valid, rd_data);
    end
  endtask

  task automatic test_random();
    logic [7:0] ed;
    logic       ev, we, re;
    logic [5:0] wa, ra;
    logic [7:0] wd;
    int         bad;
    rd_en = 1'b1; rd_addr = 6'd0;
    tick();
    ed = model[0];
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      wa = 6'($urandom_range(0, 63));
      ra = ($urandom_range(0, 3) == 0) ? wa : 6'($urandom_range(0, 63));
      wd = 8'($urandom);
      wr_en = we; wr_addr = wa; wr_data = wd;
      rd_en = re; rd_addr = ra;
      ev = re;
      if (re) ed = (FWD && we && wa == ra) ? wd : model[ra];
      if (we) model[wa] = wd;
      tick();
      n_tests++;
      if (rd_valid !== ev || rd_data !== ed || rd_err !== 1'b0) begin
        n_fail++;
        if (bad < 5) $display("FAIL random cyc %0d got v=%b d=%h e=%b want v=%b d=%h e=0", i, rd_valid, rd_data, rd_err, ev, ed);
        bad++;
      end
    end
    idle();
    tick();
    n_tests++; if (wr_err !== 1'b0) begin n_fail++; $display("FAIL random_wr_err got %b want 0", wr_err); end
  endtask

  task automatic test_busy_ignore();
    int bad;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    bad = 0;
    wr_en = 1'b1; wr_addr = 6'd3; wr_data = 8'hFF;
    rd_en = 1'b1; rd_addr = 6'd3;
    for (int c = 0; c < 64; c++) begin
      tick();
      if (rd_valid !== 1'b0) bad++;
    end
    idle();
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL busy_rd_valid got %0d valid cycles want 0", bad); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_len got busy=%b want 0", busy); end
    rd_en = 1'b1;
    for (int a = 0; a < 4; a++) begin
      rd_addr = 6'(a);
      tick();
      n_tests++;
      if (rd_valid !== 1'b1 || rd_data !== model[a]) begin
        n_fail++; $display("FAIL busy_mem addr %0d got v=%b d=%h want v=1 d=%h", a, rd_valid, rd_data, model[a]);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_rst_mid_clear();
    int n;
    wr_en = 1'b1; wr_addr = 6'd7; wr_data = 8'h77;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b1; rd_addr = 6'd7; rst = 1'b1;
    tick();
    rd_en = 1'b0; rst = 1'b0;
    n_tests++;
    if (rd_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL rst_kills_read got v=%b busy=%b want v=0 busy=1", rd_valid, busy);
    end
    for (int c = 0; c < 20; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 200) begin n++; tick(); end
    n_tests++; if (n != 64) begin n_fail++; $display("FAIL restart_len got %0d want 64", n); end
    model_clear();
    rd_en = 1'b1;
    rd_addr = 6'd7; tick();
    n_tests++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL restart_erase got %h want 00", rd_data); end
    rd_addr = 6'd1; tick();
    n_tests++; if (rd_data !== 8'h01) begin n_fail++; $display("FAIL restart_seed got %h want 01", rd_data); end
    idle();
    tick();
  endtask

  task automatic test_range_48();
    int n;
    int bad;
    rst_b = 1'b0;
    n = 0;
    while (busy_b === 1'b1 && n < 200) begin n++; tick(); end
    n_tests++; if (n != 48) begin n_fail++; $display("FAIL clear48_len got %0d want 48", n); end
    wr_en_b = 1'b1; wr_addr_b = 6'd50; wr_data_b = 8'h5A;
    tick();
    wr_en_b = 1'b0;
    n_tests++; if (wr_err_b !== 1'b1) begin n_fail++; $display("FAIL wr_err_set got %b want 1", wr_err_b); end
    tick(); tick();
    n_tests++; if (wr_err_b !== 1'b1) begin n_fail++; $display("FAIL wr_err_sticky got %b want 1", wr_err_b); end
    rd_en_b = 1'b1; rd_addr_b = 6'd50;
    tick();
    n_tests++;
    if (rd_valid_b !== 1'b1 || rd_data_b !== 8'h00 || rd_err_b !== 1'b1) begin
      n_fail++; $display("FAIL rd_oob got v=%b d=%h e=%b want v=1 d=00 e=1", rd_valid_b, rd_data_b, rd_err_b);
    end
    bad = 0;
    for (int a = 0; a < 48; a++) begin
      rd_addr_b = 6'(a);
      tick();
      if (rd_valid_b !== 1'b1 || rd_data_b !== model48[a] || rd_err_b !== 1'b0) bad++;
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL mem48_unchanged got %0d bad words want 0", bad); end
    rd_en_b = 1'b0;
    wr_en_b = 1'b1; wr_addr_b = 6'd47; wr_data_b = 8'h47;
    tick();
    wr_en_b = 1'b0; rd_en_b = 1'b1; rd_addr_b = 6'd47;
    tick();
    rd_en_b = 1'b0;
    n_tests++;
    if (rd_data_b !== 8'h47 || rd_err_b !== 1'b0) begin
      n_fail++; $display("FAIL last_word got d=%h e=%b want d=47 e=0", rd_data_b, rd_err_b);
    end
    rst_b = 1'b1;
    tick();
    n_tests++; if (wr_err_b !== 1'b0) begin n_fail++; $display("FAIL wr_err_clear got %b want 0", wr_err_b); end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_addr = '0; rd_addr = '0; wr_data = '0;
    rst_b = 1'b1; wr_en_b = 1'b0; rd_en_b = 1'b0; wr_addr_b = '0; rd_addr_b = '0; wr_data_b = '0;
    model_clear();
    test_reset();
    test_write_read();
    test_read_during_write();
    test_random();
    test_busy_ignore();
    test_rst_mid_clear();
    test_range_48();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
